// File: rtl/i2s_dac_transmitter.sv
// I2S slave DAC transmitter: serialises {left,right} stream words onto AUD_DACDAT using codec-mastered BCLK/LRCK.
// Optional: define I2S_TX_UNDERRUN_HOLD_EN to repeat the last stereo word on underrun instead of sending silence.
module i2s_dac_transmitter #(
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      AUD_BCLK,
    input  logic                      AUD_DAC_LRCK,
    input  logic [2*SAMPLE_WIDTH-1:0] s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      AUD_DACDAT,
    output logic [15:0]               underrun_count,
    output logic                      busy
);
    localparam int unsigned WORD_W = 2 * SAMPLE_WIDTH;
    localparam int unsigned CNT_W  = $clog2(SAMPLE_WIDTH + 1);
    localparam int unsigned UCNT_W = 16;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  bclk_sync;
    logic [SYNC_STAGES-1:0]  lrck_sync;
    logic                    bclk_r;
    logic                    bclk_r2;
    logic                    lrck_q;
    logic [WORD_W-1:0]       next_buf;
    logic                    next_full;
    logic [WORD_W-1:0]       active;
    logic [SAMPLE_WIDTH-1:0] shift;
    logic [CNT_W-1:0]        bit_cnt;

    logic                    bclk_s;
    logic                    lrck_s;
    logic                    bclk_fall;
    logic                    lrck_fall;
    logic                    lrck_rise;
    logic                    take;
    logic                    next_full_d;
    logic [WORD_W-1:0]       frame_word;
    logic [UCNT_W-1:0]       underrun_d;

    // Edge qualification and buffer/underrun bookkeeping
    always_comb begin
        bclk_s      = bclk_sync[SYNC_STAGES-1];
        lrck_s      = lrck_sync[SYNC_STAGES-1];
        bclk_fall   = bclk_r2 & ~bclk_r;
        lrck_fall   = bclk_fall & lrck_q & ~lrck_s;
        lrck_rise   = bclk_fall & ~lrck_q & lrck_s;
        take        = s_valid & s_ready;
        next_full_d = next_full;
        if (take)
            next_full_d = 1'b1;
        else if (lrck_fall)
            next_full_d = 1'b0;
`ifdef I2S_TX_UNDERRUN_HOLD_EN
        frame_word  = next_full ? next_buf : active;
`else
        frame_word  = next_full ? next_buf : '0;
`endif
        underrun_d  = underrun_count;
        if (lrck_fall && !next_full && underrun_count != '1)
            underrun_d = underrun_count + UCNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            bclk_sync      <= '0;
            lrck_sync      <= '0;
            bclk_r         <= 1'b0;
            bclk_r2        <= 1'b0;
            lrck_q         <= 1'b0;
            next_buf       <= '0;
            next_full      <= 1'b0;
            active         <= '0;
            shift          <= '0;
            bit_cnt        <= '0;
            s_ready        <= 1'b0;
            AUD_DACDAT     <= 1'b0;
            underrun_count <= '0;
            busy           <= 1'b0;
        end else begin
            bclk_sync      <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync      <= {lrck_sync[SYNC_STAGES-2:0], AUD_DAC_LRCK};
            bclk_r         <= bclk_s;
            bclk_r2        <= bclk_r;
            next_full      <= next_full_d;
            s_ready        <= ~next_full_d;
            underrun_count <= underrun_d;
            if (take)
                next_buf <= s_data;

            // Serial state machine advances only on BCLK falling edges
            if (bclk_fall) begin
                lrck_q <= lrck_s;
                if (lrck_fall) begin
                    state      <= LEFT;
                    busy       <= 1'b1;
                    active     <= frame_word;
                    shift      <= frame_word[WORD_W-1 -: SAMPLE_WIDTH];
                    bit_cnt    <= '0;
                    AUD_DACDAT <= 1'b0;
                end else if (state == IDLE) begin
                    AUD_DACDAT <= 1'b0;
                end else if (lrck_rise) begin
                    state      <= RIGHT;
                    shift      <= active[SAMPLE_WIDTH-1:0];
                    bit_cnt    <= '0;
                    AUD_DACDAT <= 1'b0;
                end else if (bit_cnt < CNT_W'(SAMPLE_WIDTH)) begin
                    AUD_DACDAT <= shift[SAMPLE_WIDTH-1];
                    shift      <= {shift[SAMPLE_WIDTH-2:0], 1'b0};
                    bit_cnt    <= bit_cnt + CNT_W'(1);
                end else begin
                    AUD_DACDAT <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_i2s_dac_transmitter.sv
// Directed bench for i2s_dac_transmitter: drives codec BCLK/LRCK, captures AUD_DACDAT on BCLK rising edges.
module tb_i2s_dac_transmitter;
    localparam int HALF = 160;

`ifdef I2S_TX_UNDERRUN_HOLD_EN
    localparam logic [31:0] UR_L = 32'h4000_0000;
    localparam logic [31:0] UR_R = 32'h3FFF_8000;
`else
    localparam logic [31:0] UR_L = 32'h0000_0000;
    localparam logic [31:0] UR_R = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        AUD_BCLK;
    logic        AUD_DAC_LRCK;
    logic [31:0] s_data = 32'h0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        AUD_DACDAT;
    logic [15:0] underrun_count;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] tx_q[$];
    logic [31:0] bits;

    i2s_dac_transmitter #(.SAMPLE_WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .AUD_BCLK       (AUD_BCLK),
        .AUD_DAC_LRCK   (AUD_DAC_LRCK),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .AUD_DACDAT     (AUD_DACDAT),
        .underrun_count (underrun_count),
        .busy           (busy)
    );

    always #10 clk = ~clk;

    // Stream source: present queue head, pop on handshake
    always @(negedge clk) begin
        s_valid = (tx_q.size() != 0);
        s_data  = (tx_q.size() != 0) ? tx_q[0] : 32'h0;
    end

    always @(posedge clk) begin
        if (reset_n && s_valid && s_ready)
            void'(tx_q.pop_front());
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive_slot(input logic lr, input int n, output logic [31:0] b);
        b = 32'h0;
        @(negedge clk);
        #3;
        for (int k = 0; k < n; k++) begin
            AUD_BCLK = 1'b0;
            if (k == 0)
                AUD_DAC_LRCK = lr;
            #(HALF);
            b = {b[30:0], AUD_DACDAT};
            AUD_BCLK = 1'b1;
            #(HALF);
        end
    endtask

    task automatic wait_accept(input string tag);
        int i = 0;
        while (tx_q.size() != 0 && i < 50) begin
            @(negedge clk);
            i++;
        end
        @(negedge clk);
        check(tag, 32'(tx_q.size()), 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        AUD_BCLK     = 1'b1;
        AUD_DAC_LRCK = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_dacdat", 32'(AUD_DACDAT), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_urun", 32'(underrun_count), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rel_ready", 32'(s_ready), 32'd1);

        // Test 1: partial first frame silent, then A5C3/0F01
        tx_q.push_back(32'hA5C3_0F01);
        wait_accept("t1_accept");
        check("t1_ready_full", 32'(s_ready), 32'd0);
        drive_slot(1'b1, 8, bits);
        check("t1_partial", bits, 32'h0);
        check("t1_idle_busy", 32'(busy), 32'd0);
        drive_slot(1'b0, 32, bits);
        check("t1_left", bits, 32'h52E1_8000);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_ready_back", 32'(s_ready), 32'd1);
        drive_slot(1'b1, 32, bits);
        check("t1_right", bits, 32'h0780_8000);

        // Test 2: one word then three underrun frames
        tx_q.push_back(32'h8000_7FFF);
        wait_accept("t2_accept");
        drive_slot(1'b0, 32, bits);
        check("t2_left", bits, 32'h4000_0000);
        drive_slot(1'b1, 32, bits);
        check("t2_right", bits, 32'h3FFF_8000);
        check("t2_urun0", 32'(underrun_count), 32'd0);
        for (int f = 0; f < 3; f++) begin
            drive_slot(1'b0, 32, bits);
            check($sformatf("t2_ur_left%0d", f), bits, UR_L);
            drive_slot(1'b1, 32, bits);
            check($sformatf("t2_ur_right%0d", f), bits, UR_R);
        end
        check("t2_urun3", 32'(underrun_count), 32'd3);

        // Test 3: back-to-back words, second waits for frame start
        tx_q.push_back(32'h0001_0002);
        tx_q.push_back(32'h0003_0004);
        repeat (6) @(negedge clk);
        check("t3_second_waits", 32'(tx_q.size()), 32'd1);
        drive_slot(1'b0, 32, bits);
        check("t3_left_a", bits, 32'h0000_8000);
        check("t3_second_taken", 32'(tx_q.size()), 32'd0);
        drive_slot(1'b1, 32, bits);
        check("t3_right_a", bits, 32'h0001_0000);
        drive_slot(1'b0, 32, bits);
        check("t3_left_b", bits, 32'h0001_8000);
        drive_slot(1'b1, 32, bits);
        check("t3_right_b", bits, 32'h0002_0000);
        check("t3_urun", 32'(underrun_count), 32'd3);

        // Test 4: 12-BCLK slots truncate to 11 MSBs, then full slots resume
        tx_q.push_back(32'hA5C3_0F01);
        wait_accept("t4_accept");
        drive_slot(1'b0, 12, bits);
        check("t4_short_left", bits, 32'h0000_052E);
        drive_slot(1'b1, 12, bits);
        check("t4_short_right", bits, 32'h0000_0078);
        tx_q.push_back(32'h0001_0002);
        wait_accept("t4_accept2");
        drive_slot(1'b0, 32, bits);
        check("t4_full_left", bits, 32'h0000_8000);
        drive_slot(1'b1, 32, bits);
        check("t4_full_right", bits, 32'h0001_0000);
        check("t4_urun", 32'(underrun_count), 32'd3);

        // Test 5: reset mid-left-slot discards state and the buffered word
        tx_q.push_back(32'hFFFF_0000);
        wait_accept("t5_accept");
        drive_slot(1'b0, 8, bits);
        check("t5_part_left", bits, 32'h0000_007F);
        tx_q.push_back(32'h1234_5678);
        wait_accept("t5_accept2");
        check("t5_dac_pre", 32'(AUD_DACDAT), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t5_dac_rst", 32'(AUD_DACDAT), 32'd0);
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_urun_rst", 32'(underrun_count), 32'd0);
        check("t5_ready_rst", 32'(s_ready), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        drive_slot(1'b0, 24, bits);
        check("t5_rest_left", bits, 32'h0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        drive_slot(1'b1, 32, bits);
        check("t5_right_idle", bits, 32'h0);
        check("t5_idle_busy2", 32'(busy), 32'd0);
        drive_slot(1'b0, 32, bits);
        check("t5_left_ur", bits, 32'h0);
        check("t5_busy", 32'(busy), 32'd1);
        check("t5_urun1", 32'(underrun_count), 32'd1);
        drive_slot(1'b1, 32, bits);
        check("t5_right_ur", bits, 32'h0);

        // Test 6: counter preloaded near the top must saturate
        @(negedge clk);
        force dut.underrun_count = 16'hFFFE;
        repeat (3) @(negedge clk);
        release dut.underrun_count;
        @(negedge clk);
        check("t6_preload", 32'(underrun_count), 32'h0000_FFFE);
        for (int f = 0; f < 3; f++) begin
            drive_slot(1'b0, 2, bits);
            drive_slot(1'b1, 2, bits);
            check($sformatf("t6_sat%0d", f), 32'(underrun_count), 32'h0000_FFFF);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
